// File: rtl/lc2k_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc2k_pkg
//  Description : Shared LC-2K constants and the imem_prog controller states.
//  Revision    : 1.0  initial release
// ============================================================================
package lc2k_pkg;

    // Instruction returned for any fetch outside the loaded program.
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0180_0000;

    // LC-2K opcodes, held in instruction bits [24:22].
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_NOOP = 3'd7;

    // Program-memory controller modes.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROG  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } imem_state_e;

    // Extract the opcode field of an LC-2K instruction word.
    function automatic logic [2:0] lc2k_opcode(input logic [31:0] instr);
        return instr[24:22];
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ram
//  Description : DEPTH x WIDTH instruction store, one write port and one
//                registered read port. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_ram
    import lc2k_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write on request; read data is registered and held between reads.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/imem_prog.sv
`default_nettype none
// ============================================================================
//  Module      : imem_prog
//  Description : Loadable instruction memory. A program is streamed in while
//                in program mode; in run mode fetches are answered in order
//                after READ_LAT cycles, with HALT_WORD for addresses beyond
//                the loaded program.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_prog
    import lc2k_pkg::*;
#(
    parameter int               DEPTH     = 256,
    parameter int               WIDTH     = 32,
    parameter int               READ_LAT  = 1,
    parameter logic [WIDTH-1:0] HALT_WORD = WIDTH'(HALT_WORD_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prog_en,
    input  logic                   prog_valid,
    input  logic [WIDTH-1:0]       prog_data,
    output logic                   prog_ready,
    output logic [$clog2(DEPTH):0] prog_count,
    input  logic                   fetch_req,
    input  logic [31:0]            fetch_pc,
    output logic                   fetch_ready,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_instr,
    output logic                   rsp_fault
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    imem_state_e      state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             prog_ready_q;
    logic             wr_en;
    logic             accept;
    logic             fault_now;
    logic             busy;
    logic             v1_q, f1_q;
    logic [WIDTH-1:0] ram_rdata;
    logic             out_v, out_f;
    logic [WIDTH-1:0] out_d;

    assign wr_en       = (state_q == ST_PROG) && prog_valid && prog_ready_q;
    // Dropping fetch_ready in the same cycle prog_en rises stops new fetches
    // before the controller has even left run mode.
    assign fetch_ready = (state_q == ST_RUN) && !prog_en;
    assign accept      = fetch_req && fetch_ready;
    assign fault_now   = fetch_pc >= {{(32-CW){1'b0}}, count_q};

    // Next-state and word-count rules for the mode controller.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (prog_en) begin
                    state_d = ST_PROG;
                    count_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PROG: begin
                if (wr_en) begin
                    count_d = count_q + CW'(1);
                end
                if (!prog_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (prog_en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!busy) begin
                    state_d = ST_PROG;
                    count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mode register, word count and registered loader-ready flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            prog_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prog_ready_q <= (state_d == ST_PROG) && (count_d < FULL);
        end
    end

    // First response stage: tracks the fetch whose RAM read is in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            f1_q <= 1'b0;
        end else begin
            v1_q <= accept;
            f1_q <= accept && fault_now;
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (prog_data),
        .re_i    (accept),
        .raddr_i (fetch_pc[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic             v2_q, f2_q;
            logic [WIDTH-1:0] d2_q;

            // Extra output register stage for the two-cycle latency option.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v2_q <= 1'b0;
                    f2_q <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    f2_q <= f1_q;
                end
                d2_q <= ram_rdata;
            end

            assign out_v = v2_q;
            assign out_f = f2_q;
            assign out_d = d2_q;
            assign busy  = v1_q || v2_q;
        end else begin : g_lat1
            assign out_v = v1_q;
            assign out_f = f1_q;
            assign out_d = ram_rdata;
            assign busy  = v1_q;
        end
    endgenerate

    assign prog_ready = prog_ready_q;
    assign prog_count = count_q;
    assign rsp_valid  = out_v;
    assign rsp_fault  = out_v && out_f;
    assign rsp_instr  = !out_v ? '0 : (out_f ? HALT_WORD : out_d);

endmodule
`default_nettype wire

// File: tb/tb_imem_prog.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_imem_prog
//  Description : Self-checking bench for imem_prog; drives one READ_LAT=1 and
//                one READ_LAT=2 instance with the same stimulus and compares
//                both against a cycle-level behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_prog;

    localparam int          DEPTH  = 256;
    localparam logic [31:0] HALT   = 32'h0180_0000;
    localparam int          M_IDLE = 0;
    localparam int          M_PROG = 1;
    localparam int          M_DRAIN = 2;
    localparam int          M_RUN  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_en = 1'b0;
    logic        prog_valid = 1'b0;
    logic [31:0] prog_data = '0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;

    logic        pr0, fr0, rv0, rf0, pr1, fr1, rv1, rf1;
    logic [8:0]  pc0, pc1;
    logic [31:0] ri0, ri1;

    always #5 clk = ~clk;

    imem_prog #(.DEPTH(DEPTH), .WIDTH(32), .READ_LAT(1), .HALT_WORD(HALT)) dut1 (
        .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_valid(prog_valid),
        .prog_data(prog_data), .prog_ready(pr0), .prog_count(pc0),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fr0),
        .rsp_valid(rv0), .rsp_instr(ri0), .rsp_fault(rf0)
    );

    imem_prog #(.DEPTH(DEPTH), .WIDTH(32), .READ_LAT(2), .HALT_WORD(HALT)) dut2 (
        .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_valid(prog_valid),
        .prog_data(prog_data), .prog_ready(pr1), .prog_count(pc1),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fr1),
        .rsp_valid(rv1), .rsp_instr(ri1), .rsp_fault(rf1)
    );

    // Behavioural model: per instance mode, loaded-word count, memory image
    // and a queue of expected responses stamped with their due cycle.
    typedef struct {
        int          due;
        logic [31:0] instr;
        logic        fault;
    } rsp_t;

    rsp_t        q0[$];
    rsp_t        q1[$];
    int          mode_m [2];
    int          count_m [2];
    bit          shown_m [2];
    int          lat_m [2];
    logic [31:0] mem_m [2][DEPTH];
    int          ecount = 0;
    bit          armed = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] prog4 [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the rules for one rising edge to instance d.
    task automatic model_edge(input int d);
        rsp_t r;
        int   qsize;
        qsize = (d == 0) ? q0.size() : q1.size();
        if (!rst_n) begin
            mode_m[d]  = M_IDLE;
            count_m[d] = 0;
            shown_m[d] = 1'b0;
            if (d == 0) q0.delete(); else q1.delete();
        end else begin
            case (mode_m[d])
                M_IDLE: begin
                    if (prog_en) begin
                        mode_m[d]  = M_PROG;
                        count_m[d] = 0;
                    end else begin
                        mode_m[d] = M_RUN;
                    end
                end
                M_PROG: begin
                    if (prog_valid && count_m[d] < DEPTH) begin
                        mem_m[d][count_m[d]] = prog_data;
                        count_m[d]++;
                    end
                    if (!prog_en) mode_m[d] = M_RUN;
                end
                M_RUN: begin
                    if (prog_en) begin
                        mode_m[d] = M_DRAIN;
                    end else if (fetch_req) begin
                        r.due   = ecount + lat_m[d];
                        r.fault = (fetch_pc >= 32'(count_m[d]));
                        r.instr = r.fault ? HALT : mem_m[d][fetch_pc[7:0]];
                        if (d == 0) q0.push_back(r); else q1.push_back(r);
                    end
                end
                default: begin
                    if (qsize == 0 && !shown_m[d]) begin
                        mode_m[d]  = M_PROG;
                        count_m[d] = 0;
                    end
                end
            endcase
        end
    endtask

    // Compare the registered outputs of instance d with the model.
    task automatic model_out(input int d, input logic pr, input logic [8:0] pc,
                             input logic rv, input logic [31:0] ri, input logic rf);
        rsp_t r;
        bit   have;
        have = 1'b0;
        r.due = 0; r.instr = '0; r.fault = 1'b0;
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].due == ecount) begin r = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].due == ecount) begin r = q1.pop_front(); have = 1'b1; end
        end
        shown_m[d] = have;
        chk($sformatf("lat%0d prog_ready cyc%0d", d + 1, ecount), 64'(pr),
            64'(mode_m[d] == M_PROG && count_m[d] < DEPTH));
        chk($sformatf("lat%0d prog_count cyc%0d", d + 1, ecount), 64'(pc), 64'(count_m[d]));
        chk($sformatf("lat%0d rsp_valid cyc%0d", d + 1, ecount), 64'(rv), 64'(have));
        chk($sformatf("lat%0d rsp_instr cyc%0d", d + 1, ecount), 64'(ri), have ? 64'(r.instr) : 64'd0);
        chk($sformatf("lat%0d rsp_fault cyc%0d", d + 1, ecount), 64'(rf), have ? 64'(r.fault) : 64'd0);
    endtask

    // One clock: check fetch_ready against current inputs, advance the model,
    // then check registered outputs on the falling edge.
    task automatic tick();
        #1;
        if (armed) begin
            chk($sformatf("lat1 fetch_ready cyc%0d", ecount), 64'(fr0), 64'(mode_m[0] == M_RUN && !prog_en));
            chk($sformatf("lat2 fetch_ready cyc%0d", ecount), 64'(fr1), 64'(mode_m[1] == M_RUN && !prog_en));
        end
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        ecount++;
        if (!rst_n) armed = 1'b1;
        @(negedge clk);
        if (armed) begin
            model_out(0, pr0, pc0, rv0, ri0, rf0);
            model_out(1, pr1, pc1, rv1, ri1, rf1);
        end
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        tick();
    endtask

    initial begin
        lat_m[0] = 1;
        lat_m[1] = 2;
        prog4[0] = 32'h000E_0001;
        prog4[1] = 32'h0013_0004;
        prog4[2] = 32'h006F_0005;
        prog4[3] = 32'h0180_0000;

        // Reset state.
        rst_n = 1'b0;
        repeat (2) tick();

        // Load the four-word program and fetch it back to back.
        rst_n   = 1'b1;
        prog_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            prog_valid = 1'b1;
            prog_data  = prog4[i];
            tick();
        end
        prog_valid = 1'b0;
        prog_en    = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) fetch(32'(i));
        fetch(32'd4);
        fetch(32'hFFFF_FFFF);
        fetch_req = 1'b0;
        repeat (3) tick();

        // Overfill: 258 words offered with prog_valid held high.
        prog_en = 1'b1;
        repeat (4) tick();
        prog_valid = 1'b1;
        for (int i = 0; i < 258; i++) begin
            prog_data = $urandom;
            tick();
        end
        prog_valid = 1'b0;
        prog_en    = 1'b0;
        tick();
        fetch(32'd0);
        fetch(32'd255);
        fetch(32'd256);
        fetch(32'd300);
        fetch_req = 1'b0;
        repeat (2) tick();

        // Three fetches, then program mode requested with a fetch still offered.
        for (int i = 0; i < 3; i++) fetch(32'($urandom_range(0, 255)));
        prog_en  = 1'b1;
        fetch_pc = 32'd1;
        tick();
        fetch_req = 1'b0;
        repeat (5) tick();

        // Randomized load / run / drain rounds.
        for (int round = 0; round < 4; round++) begin
            int n;
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                prog_valid = ($urandom_range(0, 3) != 0);
                prog_data  = $urandom;
                tick();
            end
            prog_valid = 1'b1;
            prog_data  = $urandom;
            prog_en    = 1'b0;
            tick();
            prog_valid = 1'b0;
            for (int i = 0; i < 60; i++) begin
                fetch_req = ($urandom_range(0, 3) != 0);
                fetch_pc  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
                tick();
            end
            prog_en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                fetch_req = $urandom_range(0, 1) == 1;
                tick();
            end
            fetch_req = 1'b0;
        end

        // Reset in the middle of a load; afterwards every fetch must fault.
        for (int i = 0; i < 2; i++) begin
            prog_valid = 1'b1;
            prog_data  = prog4[i];
            tick();
        end
        prog_valid = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n   = 1'b1;
        prog_en = 1'b0;
        tick();
        fetch(32'd0);
        fetch_req = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
